// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
//
// Purpose:
//   This is a multi-cycle shift-add multiplier. It computes the low 32 bits of
//   multiplicand * multiplier by borrowing the shared 32-bit ALU. The result
//   is the same for signed and unsigned operands, so it serves the MIPS mul
//   (low word) instruction extension.
//
//   Each RUN cycle handles one multiplier bit:
//     - When the bit is 1, it requests the ALU and adds the shifted
//       multiplicand to the accumulator.
//     - When the bit is 0, it only shifts.
//   The run ends early as soon as the remaining multiplier bits are all zero.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   begin a multiply (only honoured in IDLE)
//   multiplicand in  32   operand A, latched on an accepted start
//   multiplier   in  32   operand B, latched on an accepted start
//   busy         out  1   high from the cycle after accepted start through DONE
//   done         out  1   one-cycle pulse, product valid
//   product      out 32   registered low word of A*B, held until replaced
//   alu_req      out  1   ALU wanted this cycle
//   alu_gnt      in   1   datapath grants the ALU this cycle
//   alu_src1     out 32   ALU operand 1 (accumulator)
//   alu_src2     out 32   ALU operand 2 (shifted multiplicand)
//   alu_ctr      out  3   ALU operation code
//   alu_result   in  32   ALU combinational result for this cycle
// ---------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter logic [2:0] ADD_CTR  = 3'b010,
    parameter logic [2:0] IDLE_CTR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [2:0]  alu_ctr,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] acc;
    logic [5:0]  count;

    logic        b_zero;
    logic        add_step;

    assign b_zero = (b_reg == 32'd0);

    // An add step is needed only in RUN, while multiplier bits remain and the
    // current low bit is set. This term is built purely from registered state,
    // so alu_req never depends combinationally on alu_gnt.
    assign add_step = (state == RUN) && !b_zero && b_reg[0];

    // Drive the ALU interface. When no add is wanted, the operands return to
    // zero and the opcode returns to the idle code, so the shared ALU sees
    // quiet inputs.
    always_comb begin
        alu_req  = 1'b0;
        alu_src1 = 32'd0;
        alu_src2 = 32'd0;
        alu_ctr  = IDLE_CTR;
        if (add_step) begin
            alu_req  = 1'b1;
            alu_src1 = acc;
            alu_src2 = a_reg;
            alu_ctr  = ADD_CTR;
        end
    end

    // Control FSM and datapath registers.
    // - A denied grant on an add step holds every register. The request then
    //   repeats with identical operands on the next cycle.
    // - The product is captured on the transition into DONE, so it is already
    //   valid during the cycle in which done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            acc     <= 32'd0;
            count   <= 6'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= multiplicand;
                        b_reg <= multiplier;
                        acc   <= 32'd0;
                        count <= 6'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (b_zero) begin
                        product <= acc;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (b_reg[0]) begin
                        if (alu_gnt) begin
                            acc   <= alu_result;
                            a_reg <= a_reg << 1;
                            b_reg <= b_reg >> 1;
                            count <= count + 6'd1;
                        end
                    end else begin
                        a_reg <= a_reg << 1;
                        b_reg <= b_reg >> 1;
                        count <= count + 6'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Each step consumes one multiplier bit. The step count therefore can
    // never exceed the operand width.
    assert property (@(posedge clk) disable iff (!rst_n) count <= 6'd32);

    // The done pulse always falls inside the busy window.
    assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Testbench for alu_mul_sequencer. It models the shared ALU as a plain adder
// that responds to the ADD code. It checks the following, using a vector
// table plus hand-written sequences:
//   - product, latency and the number of granted ALU requests;
//   - stalls on a denied grant;
//   - that start is ignored while busy;
//   - asynchronous reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [2:0]  alu_ctr;
    logic [31:0] alu_result;

    int compared;
    int mismatched;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        int          lat;
        int          reqs;
    } vec_t;

    vec_t vecs[10];

    alu_mul_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .alu_req      (alu_req),
        .alu_gnt      (alu_gnt),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctr      (alu_ctr),
        .alu_result   (alu_result)
    );

    // Shared ALU model: adds when given the ADD code, otherwise outputs zero.
    assign alu_result = (alu_ctr == 3'b010) ? (alu_src1 + alu_src2) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the expected value and log any miss.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one multiply from start to done, then verify every observable result.
    // - stalls: the number of denied grants applied to the first requesting step.
    // - poke: pulses start once mid-run and once in the done cycle, each with
    //   different operands; both pulses must be ignored.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_prod, input int exp_lat, input int exp_reqs,
                                 input int stalls, input bit poke);
        int          edges;
        int          lat;
        int          reqs;
        int          stall_left;
        bit          captured;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  ct;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        alu_gnt      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges      = 1;
        lat        = 0;
        reqs       = 0;
        stall_left = stalls;
        captured   = 1'b0;
        s1 = 32'd0;
        s2 = 32'd0;
        ct = 3'd0;
        while (edges < 60) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = edges;
                break;
            end
            if (poke && edges == 2) begin
                multiplicand = 32'hDEADBEEF;
                multiplier   = 32'h00000007;
                start        = 1'b1;
            end
            if (alu_req) begin
                if (!captured) begin
                    captured = 1'b1;
                    s1 = alu_src1;
                    s2 = alu_src2;
                    ct = alu_ctr;
                end else if (reqs == 0) begin
                    checkOutput({name, " stall_src1"}, alu_src1, s1);
                    checkOutput({name, " stall_src2"}, alu_src2, s2);
                    checkOutput({name, " stall_ctr"}, {29'd0, alu_ctr}, {29'd0, ct});
                end
                if (stall_left > 0) begin
                    alu_gnt = 1'b0;
                    stall_left--;
                end else begin
                    alu_gnt = 1'b1;
                    reqs++;
                end
            end else begin
                alu_gnt = 1'b1;
            end
            @(posedge clk);
            edges++;
        end
        alu_gnt = 1'b1;
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " product"}, product, exp_prod);
        checkOutput({name, " busy_at_done"}, {31'd0, busy}, 32'd1);
        checkOutput({name, " alu_reqs"}, reqs, exp_reqs);
        if (stalls > 0) begin
            checkOutput({name, " first_req_src1"}, s1, 32'd0);
            checkOutput({name, " first_req_src2"}, s2, a << 1);
            checkOutput({name, " first_req_ctr"}, {29'd0, ct}, 32'd2);
        end
        if (poke) begin
            multiplicand = 32'h0BADF00D;
            multiplier   = 32'h00000003;
            start        = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, " done_pulse_end"}, {31'd0, done}, 32'd0);
        checkOutput({name, " busy_after"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " product_hold"}, product, exp_prod);
        @(negedge clk);
        checkOutput({name, " idle_again"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{a: 32'd3,          b: 32'd5,          prod: 32'd15,         lat: 5,  reqs: 2};
        vecs[1] = '{a: 32'h12345678,   b: 32'd0,          prod: 32'd0,          lat: 2,  reqs: 0};
        vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   prod: 32'h00000001,   lat: 34, reqs: 32};
        vecs[3] = '{a: 32'd2,          b: 32'd2,          prod: 32'd4,          lat: 4,  reqs: 1};
        vecs[4] = '{a: 32'h00000010,   b: 32'd3,          prod: 32'h00000030,   lat: 4,  reqs: 2};
        vecs[5] = '{a: 32'hFFFFFFFE,   b: 32'd3,          prod: 32'hFFFFFFFA,   lat: 4,  reqs: 2};
        vecs[6] = '{a: 32'h80000000,   b: 32'd2,          prod: 32'h00000000,   lat: 4,  reqs: 1};
        vecs[7] = '{a: 32'd1,          b: 32'h80000000,   prod: 32'h80000000,   lat: 34, reqs: 1};
        vecs[8] = '{a: 32'h12345678,   b: 32'd1,          prod: 32'h12345678,   lat: 3,  reqs: 1};
        vecs[9] = '{a: 32'h0000FFFF,   b: 32'h00010001,   prod: 32'hFFFFFFFF,   lat: 19, reqs: 2};

        rst_n        = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        alu_gnt      = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset product", product, 32'd0);
        checkOutput("reset alu_req", {31'd0, alu_req}, 32'd0);
        checkOutput("reset alu_src1", alu_src1, 32'd0);
        checkOutput("reset alu_src2", alu_src2, 32'd0);
        checkOutput("reset alu_ctr", {29'd0, alu_ctr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod,
                          vecs[i].lat, vecs[i].reqs, 0, 1'b0);
        end

        // The first requesting step is denied three times. The run stretches by
        // three cycles, and the product must be unchanged.
        applyStimulus("stall7x6", 32'd7, 32'd6, 32'd42, 8, 2, 3, 1'b0);

        // Start pulses arrive mid-run and in the done cycle; both must be ignored.
        applyStimulus("busy_start", 32'd5, 32'd3, 32'd15, 4, 2, 0, 1'b1);

        // Reset arrives mid-run: outputs clear at once and no done pulse follows.
        @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'h80000000;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrun busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst busy", {31'd0, busy}, 32'd0);
        checkOutput("midrun_rst done", {31'd0, done}, 32'd0);
        checkOutput("midrun_rst product", product, 32'd0);
        checkOutput("midrun_rst alu_req", {31'd0, alu_req}, 32'd0);
        checkOutput("midrun_rst alu_ctr", {29'd0, alu_ctr}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midrun_rst no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        applyStimulus("after_rst2x2", 32'd2, 32'd2, 32'd4, 4, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
